// File: rtl/stereo_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the stereo
// window feeder and its row buffer.
package stereo_pkg;
   localparam int WIN_DEF       = 15;
   localparam int DATA_SIZE_DEF = 8;
   localparam int IMG_W_DEF     = 64;
   localparam int MAX_DISP_DEF  = 64;

   localparam int SAD_BITS  = $clog2(WIN_DEF * WIN_DEF) + DATA_SIZE_DEF;
   localparam int DISP_BITS = $clog2(MAX_DISP_DEF);
   localparam int IMG_W_ARR = $clog2(IMG_W_DEF);

   typedef enum logic [2:0] {
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_CLR,
      S_EMIT,
      S_SHIFT
   } state_t;
endpackage

// File: rtl/stereo_window_feeder_row_shift_buffer.sv
// WIN x IMG_W pixel store: single-pixel write, or whole-window shift by one
// row toward row 0 (oldest). Storage is the flattened output itself.
module row_shift_buffer
   import stereo_pkg::*;
#(
   parameter int WIN       = WIN_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int IMG_W     = IMG_W_DEF,
   localparam int ROW_W    = $clog2(WIN),
   localparam int COL_W    = $clog2(IMG_W),
   localparam int ARR_W    = DATA_SIZE * IMG_W * WIN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [ROW_W-1:0]     wr_row,
   input  logic [COL_W-1:0]     wr_col,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic                 shift,
   output logic [ARR_W-1:0]     arr
);
   localparam int LINE_W = DATA_SIZE * IMG_W;
   localparam int IDX_W  = $clog2(ARR_W);

   logic [ARR_W-1:0] arr_q, arr_d;
   logic [IDX_W-1:0] base;

   always_comb begin
      arr_d = arr_q;
      base  = IDX_W'((int'(wr_row) * IMG_W + int'(wr_col)) * DATA_SIZE);
      // Row WIN-1 keeps stale data after a shift; it is refilled before use.
      if (shift)
         arr_d[ARR_W-LINE_W-1:0] = arr_q[ARR_W-1:LINE_W];
      else if (wr_en)
         arr_d[base +: DATA_SIZE] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst) arr_q <= '0;
      else      arr_q <= arr_d;
   end

   assign arr = arr_q;
endmodule

// File: rtl/stereo_window_feeder.sv
// Buffers WIN image rows and sequences the disparity core column by column.
// Define STEREO_WIN_COUNT_EN to enable the win_count window counter.
module stereo_window_feeder
   import stereo_pkg::*;
#(
   parameter int WIN       = WIN_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int IMG_W     = IMG_W_DEF,
   parameter int MAX_DISP  = MAX_DISP_DEF,
   localparam int DISP_W   = $clog2(MAX_DISP),
   localparam int COL_W    = $clog2(IMG_W),
   localparam int ROW_W    = $clog2(WIN),
   localparam int ARR_W    = DATA_SIZE * IMG_W * WIN
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   input  logic                 pix_sof,
   input  logic [DATA_SIZE-1:0] pix_L,
   input  logic [DATA_SIZE-1:0] pix_R,
   output logic [ARR_W-1:0]     array_L,
   output logic [ARR_W-1:0]     array_R,
   output logic [COL_W-1:0]     col_index,
   output logic                 input_ready,
   output logic                 core_rst,
   input  logic                 done,
   input  logic [DISP_W-1:0]    disp_in,
   output logic                 disp_valid,
   input  logic                 disp_ready,
   output logic [DISP_W-1:0]    disp_out,
   output logic [15:0]          win_count
);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [COL_W-1:0] COL_STOP = COL_W'(IMG_W - WIN);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(WIN - 1);

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
   logic [COL_W-1:0]  col_cnt_q, col_cnt_d;
   logic [COL_W-1:0]  col_index_q, col_index_d;
   logic              pix_ready_q, pix_ready_d;
   logic              input_ready_q, input_ready_d;
   logic              core_rst_q, core_rst_d;
   logic              disp_valid_q, disp_valid_d;
   logic [DISP_W-1:0] disp_out_q, disp_out_d;

   logic             xfer;
   logic             wr_en;
   logic             shift_en;
   logic [ROW_W-1:0] wr_row;
   logic [COL_W-1:0] wr_col;

   assign xfer = pix_valid && pix_ready_q;

   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      col_cnt_d     = col_cnt_q;
      col_index_d   = col_index_q;
      pix_ready_d   = pix_ready_q;
      input_ready_d = 1'b0;
      core_rst_d    = 1'b0;
      disp_valid_d  = disp_valid_q;
      disp_out_d    = disp_out_q;
      wr_en         = 1'b0;
      wr_row        = row_cnt_q;
      wr_col        = col_cnt_q;
      shift_en      = 1'b0;
      unique case (state_q)
         S_FILL: begin
            if (xfer) begin
               wr_en = 1'b1;
               // A start-of-frame pixel restarts the window from scratch.
               if (pix_sof) begin
                  wr_row    = '0;
                  wr_col    = '0;
                  row_cnt_d = '0;
                  col_cnt_d = COL_W'(1);
               end else if (col_cnt_q == COL_LAST) begin
                  col_cnt_d = '0;
                  if (row_cnt_q != ROW_LAST) begin
                     row_cnt_d = row_cnt_q + 1'b1;
                  end else begin
                     state_d       = S_ISSUE;
                     pix_ready_d   = 1'b0;
                     input_ready_d = 1'b1;
                  end
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (done) begin
               disp_out_d = disp_in;
               core_rst_d = 1'b1;
               state_d    = S_CLR;
            end
         end
         S_CLR: begin
            disp_valid_d = 1'b1;
            state_d      = S_EMIT;
         end
         S_EMIT: begin
            if (disp_ready) begin
               disp_valid_d = 1'b0;
               if (col_index_q < COL_STOP) begin
                  col_index_d   = col_index_q + 1'b1;
                  input_ready_d = 1'b1;
                  state_d       = S_ISSUE;
               end else begin
                  col_index_d = '0;
                  state_d     = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            shift_en    = 1'b1;
            row_cnt_d   = ROW_LAST;
            col_cnt_d   = '0;
            pix_ready_d = 1'b1;
            state_d     = S_FILL;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_FILL;
         row_cnt_q     <= '0;
         col_cnt_q     <= '0;
         col_index_q   <= '0;
         pix_ready_q   <= 1'b1;
         input_ready_q <= 1'b0;
         core_rst_q    <= 1'b0;
         disp_valid_q  <= 1'b0;
         disp_out_q    <= '0;
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         col_cnt_q     <= col_cnt_d;
         col_index_q   <= col_index_d;
         pix_ready_q   <= pix_ready_d;
         input_ready_q <= input_ready_d;
         core_rst_q    <= core_rst_d;
         disp_valid_q  <= disp_valid_d;
         disp_out_q    <= disp_out_d;
      end
   end

   row_shift_buffer #(
      .WIN       (WIN),
      .DATA_SIZE (DATA_SIZE),
      .IMG_W     (IMG_W)
   ) u_buf_l (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (pix_L),
      .shift   (shift_en),
      .arr     (array_L)
   );

   row_shift_buffer #(
      .WIN       (WIN),
      .DATA_SIZE (DATA_SIZE),
      .IMG_W     (IMG_W)
   ) u_buf_r (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (pix_R),
      .shift   (shift_en),
      .arr     (array_R)
   );

`ifdef STEREO_WIN_COUNT_EN
   logic [15:0] win_count_q, win_count_d;

   always_comb win_count_d = win_count_q + 16'(input_ready_q);

   always_ff @(posedge clk) begin
      if (!rst) win_count_q <= '0;
      else      win_count_q <= win_count_d;
   end

   assign win_count = win_count_q;
`else
   assign win_count = '0;
`endif

   assign pix_ready   = pix_ready_q;
   assign input_ready = input_ready_q;
   assign core_rst    = core_rst_q;
   assign disp_valid  = disp_valid_q;
   assign disp_out    = disp_out_q;
   assign col_index   = col_index_q;
endmodule

// File: tb/tb_stereo_window_feeder.sv
// Randomized bench for stereo_window_feeder with a row-queue window model
// and a behavioural disparity-core responder.
module tb_stereo_window_feeder;
   localparam int WIN  = 15;
   localparam int DS   = 8;
   localparam int IW   = 64;
   localparam int MD   = 64;
   localparam int DW   = $clog2(MD);
   localparam int CW   = $clog2(IW);
   localparam int LINE = DS * IW;
   localparam int ARR  = LINE * WIN;
   localparam int NWIN = IW - WIN + 1;

   typedef logic [LINE-1:0] line_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          pix_valid = 1'b0;
   logic          pix_sof = 1'b0;
   logic          done = 1'b0;
   logic          disp_ready = 1'b0;
   logic [DS-1:0] pix_L = '0;
   logic [DS-1:0] pix_R = '0;
   logic [DW-1:0] disp_in = '0;

   logic           pix_ready, input_ready, core_rst, disp_valid;
   logic [ARR-1:0] array_L, array_R;
   logic [CW-1:0]  col_index;
   logic [DW-1:0]  disp_out;
   logic [15:0]    win_count;

   int checks = 0;
   int fails = 0;
   int ir_pulses = 0;
   int wins = 0;
   line_t qL[$];
   line_t qR[$];

   stereo_window_feeder #(
      .WIN(WIN), .DATA_SIZE(DS), .IMG_W(IW), .MAX_DISP(MD)
   ) dut (
      .clk(clk), .rst(rst),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
      .pix_L(pix_L), .pix_R(pix_R),
      .array_L(array_L), .array_R(array_R),
      .col_index(col_index), .input_ready(input_ready), .core_rst(core_rst),
      .done(done), .disp_in(disp_in),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_out(disp_out),
      .win_count(win_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (input_ready === 1'b1) ir_pulses++;

   function automatic line_t const_line(input logic [DS-1:0] v);
      line_t x;
      for (int c = 0; c < IW; c++) x[c*DS +: DS] = v;
      return x;
   endfunction

   function automatic line_t rand_line();
      line_t x;
      for (int c = 0; c < IW; c++) x[c*DS +: DS] = DS'($urandom);
      return x;
   endfunction

   // Expected window: the WIN most recent complete rows, oldest in row 0.
   function automatic logic [ARR-1:0] model_win(input bit right);
      logic [ARR-1:0] e;
      int n;
      e = '0;
      n = qL.size();
      for (int r = 0; r < WIN; r++)
         e[r*LINE +: LINE] = right ? qR[n-WIN+r] : qL[n-WIN+r];
      return e;
   endfunction

   function automatic int first_diff(input logic [ARR-1:0] a, input logic [ARR-1:0] b);
      for (int k = 0; k < ARR / DS; k++)
         if (a[k*DS +: DS] !== b[k*DS +: DS]) return k;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic abort(input string what);
      checks++;
      fails++;
      $display("FAIL %s: no response within cycle budget", what);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $fatal(1, "bench stopped");
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      done = 1'b0;
      disp_ready = 1'b0;
      tick();
      tick();
      qL.delete();
      qR.delete();
      wins = 0;
   endtask

   task automatic send_pix(input logic [DS-1:0] l, input logic [DS-1:0] r, input logic sof);
      int n;
      n = 0;
      if ($urandom_range(0, 7) == 0) tick();
      pix_valid = 1'b1;
      pix_L = l;
      pix_R = r;
      pix_sof = sof;
      while (pix_ready !== 1'b1) begin
         if (n == 1000) abort("pix_ready_wait");
         n++;
         tick();
      end
      tick();
      pix_valid = 1'b0;
      pix_sof = 1'b0;
   endtask

   task automatic send_row(input line_t l, input line_t r, input logic sof);
      for (int c = 0; c < IW; c++)
         send_pix(l[c*DS +: DS], r[c*DS +: DS], sof && (c == 0));
      if (sof) begin
         qL.delete();
         qR.delete();
      end
      qL.push_back(l);
      qR.push_back(r);
      if (qL.size() > WIN) begin
         qL.delete(0);
         qR.delete(0);
      end
   endtask

   task automatic serve_window(input int exp_col, input int lat,
                               input logic [DW-1:0] d, input int stall);
      int n;
      int k;
      logic [ARR-1:0] eL, eR;
      logic [15:0] ewc;
      n = 0;
      while (input_ready !== 1'b1) begin
         if (n == 2000) abort("issue_wait");
         n++;
         tick();
      end
      eL = model_win(1'b0);
      eR = model_win(1'b1);
      wins++;
      checks++;
      if (col_index !== CW'(exp_col)) begin
         fails++;
         $display("FAIL col_index: got %0d expected %0d", col_index, exp_col);
      end
      checks++;
      k = first_diff(array_L, eL);
      if (k >= 0) begin
         fails++;
         $display("FAIL array_L col %0d: byte %0d got %0h expected %0h",
                  exp_col, k, array_L[k*DS +: DS], eL[k*DS +: DS]);
      end
      checks++;
      k = first_diff(array_R, eR);
      if (k >= 0) begin
         fails++;
         $display("FAIL array_R col %0d: byte %0d got %0h expected %0h",
                  exp_col, k, array_R[k*DS +: DS], eR[k*DS +: DS]);
      end
      tick();
      checks++;
      if (input_ready !== 1'b0) begin
         fails++;
         $display("FAIL input_ready_width: got %b expected 0", input_ready);
      end
      for (int i = 1; i < lat; i++) begin
         pix_valid = 1'b1;
         pix_L = DS'($urandom);
         pix_R = DS'($urandom);
         tick();
         checks++;
         if (core_rst !== 1'b0 || disp_valid !== 1'b0 || col_index !== CW'(exp_col)) begin
            fails++;
            $display("FAIL wait_hold: got core_rst=%b disp_valid=%b col=%0d expected 0 0 %0d",
                     core_rst, disp_valid, col_index, exp_col);
         end
      end
      pix_valid = 1'b0;
      disp_in = d;
      done = 1'b1;
      tick();
      done = 1'b0;
      disp_in = DW'($urandom);
      checks++;
      if (core_rst !== 1'b1 || disp_valid !== 1'b0) begin
         fails++;
         $display("FAIL core_rst_pulse: got core_rst=%b disp_valid=%b expected 1 0",
                  core_rst, disp_valid);
      end
      tick();
      checks++;
      if (core_rst !== 1'b0 || disp_valid !== 1'b1 || disp_out !== d) begin
         fails++;
         $display("FAIL emit: got core_rst=%b disp_valid=%b disp_out=%0d expected 0 1 %0d",
                  core_rst, disp_valid, disp_out, d);
      end
`ifdef STEREO_WIN_COUNT_EN
      ewc = 16'(wins);
`else
      ewc = 16'd0;
`endif
      checks++;
      if (win_count !== ewc) begin
         fails++;
         $display("FAIL win_count: got %0d expected %0d", win_count, ewc);
      end
      for (int i = 0; i < stall; i++) begin
         done = 1'($urandom);
         tick();
         checks++;
         if (disp_valid !== 1'b1 || disp_out !== d || input_ready !== 1'b0 ||
             col_index !== CW'(exp_col)) begin
            fails++;
            $display("FAIL backpressure: got valid=%b out=%0d ir=%b col=%0d expected 1 %0d 0 %0d",
                     disp_valid, disp_out, input_ready, col_index, d, exp_col);
         end
      end
      done = 1'b0;
      disp_ready = 1'b1;
      tick();
      disp_ready = 1'b0;
      checks++;
      if (disp_valid !== 1'b0) begin
         fails++;
         $display("FAIL emit_release: got disp_valid=%b expected 0", disp_valid);
      end
   endtask

   task automatic serve_row(input int start, input int stall_mod);
      int p0;
      p0 = ir_pulses;
      for (int c = start; c < NWIN; c++)
         serve_window(c, $urandom_range(1, 6), DW'($urandom_range(1, MD - 1)),
                      (stall_mod > 0 && c % stall_mod == 3) ? 10 : 0);
      checks++;
      if (ir_pulses - p0 != NWIN - start) begin
         fails++;
         $display("FAIL pulses_per_row: got %0d expected %0d", ir_pulses - p0, NWIN - start);
      end
      checks++;
      if (pix_ready !== 1'b0 || input_ready !== 1'b0 || col_index !== '0) begin
         fails++;
         $display("FAIL shift_state: got pix_ready=%b ir=%b col=%0d expected 0 0 0",
                  pix_ready, input_ready, col_index);
      end
      tick();
      checks++;
      if (pix_ready !== 1'b1) begin
         fails++;
         $display("FAIL refill_ready: got %b expected 1", pix_ready);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (pix_ready !== 1'b1 || input_ready !== 1'b0 || disp_valid !== 1'b0 ||
          col_index !== '0 || core_rst !== 1'b0 || disp_out !== '0) begin
         fails++;
         $display("FAIL reset_ctrl: got rdy=%b ir=%b dv=%b col=%0d crst=%b out=%0d expected 1 0 0 0 0 0",
                  pix_ready, input_ready, disp_valid, col_index, core_rst, disp_out);
      end
      checks++;
      if (array_L !== '0 || array_R !== '0) begin
         fails++;
         $display("FAIL reset_arrays: got nonzero window expected all zero");
      end
      checks++;
      if (win_count !== 16'd0) begin
         fails++;
         $display("FAIL reset_win_count: got %0d expected 0", win_count);
      end
      rst = 1'b1;
   endtask

   task automatic test_fill();
      int p0;
      p0 = ir_pulses;
      for (int r = 0; r < WIN; r++) begin
         if (r == WIN - 1) begin
            checks++;
            if (ir_pulses != p0) begin
               fails++;
               $display("FAIL early_issue: got %0d pulses expected 0", ir_pulses - p0);
            end
         end
         send_row(const_line(DS'(r)), const_line(DS'(r + 1)), 1'b0);
      end
      checks++;
      if (input_ready !== 1'b1 || pix_ready !== 1'b0) begin
         fails++;
         $display("FAIL fill_issue: got ir=%b pix_ready=%b expected 1 0", input_ready, pix_ready);
      end
      checks++;
      if (array_L[(14*IW)*DS +: DS] !== 8'h0E) begin
         fails++;
         $display("FAIL fill_row14: got %0h expected 0e", array_L[(14*IW)*DS +: DS]);
      end
      serve_window(0, 5, DW'(7), 0);
   endtask

   task automatic test_sweep();
      serve_row(1, 0);
      send_row(const_line(DS'(15)), const_line(DS'(16)), 1'b0);
      checks++;
      if (array_L[0 +: DS] !== 8'h01 || array_L[(14*IW)*DS +: DS] !== 8'h0F) begin
         fails++;
         $display("FAIL shift_rows: got row0=%0h row14=%0h expected 01 0f",
                  array_L[0 +: DS], array_L[(14*IW)*DS +: DS]);
      end
      serve_row(0, 0);
   endtask

   task automatic test_backpressure();
      send_row(rand_line(), rand_line(), 1'b0);
      serve_row(0, 10);
   endtask

   task automatic test_resync();
      int p0;
      apply_reset();
      rst = 1'b1;
      p0 = ir_pulses;
      for (int r = 0; r < 3; r++) send_row(rand_line(), rand_line(), 1'b0);
      for (int c = 0; c < 10; c++) send_pix(DS'($urandom), DS'($urandom), 1'b0);
      send_row(rand_line(), rand_line(), 1'b1);
      for (int r = 0; r < WIN - 2; r++) send_row(rand_line(), rand_line(), 1'b0);
      checks++;
      if (ir_pulses != p0 || input_ready !== 1'b0) begin
         fails++;
         $display("FAIL resync_early: got %0d pulses ir=%b expected 0 0", ir_pulses - p0, input_ready);
      end
      send_row(rand_line(), rand_line(), 1'b0);
      checks++;
      if (input_ready !== 1'b1) begin
         fails++;
         $display("FAIL resync_issue: got %b expected 1", input_ready);
      end
      serve_window(0, $urandom_range(1, 6), DW'($urandom_range(1, MD - 1)), 0);
   endtask

   task automatic test_midop_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (pix_ready !== 1'b1 || input_ready !== 1'b0 || disp_valid !== 1'b0 ||
          core_rst !== 1'b0 || disp_out !== '0 || col_index !== '0) begin
         fails++;
         $display("FAIL midop_reset: got rdy=%b ir=%b dv=%b crst=%b out=%0d col=%0d expected 1 0 0 0 0 0",
                  pix_ready, input_ready, disp_valid, core_rst, disp_out, col_index);
      end
      checks++;
      if (array_L !== '0 || array_R !== '0 || win_count !== 16'd0) begin
         fails++;
         $display("FAIL midop_reset_state: got win_count=%0d or nonzero window expected all zero",
                  win_count);
      end
      rst = 1'b1;
      qL.delete();
      qR.delete();
      wins = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_sweep();
      test_backpressure();
      test_resync();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
